// File: rtl/microwave_timer.sv
// Four-digit BCD mm:ss cooking countdown driven by a synchronised 1 Hz pulse train.
// Optional pause-on-stop behaviour is enabled by defining TIMER_PAUSE_EN.
module microwave_timer #(
  parameter bit START_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       pgt_1Hz,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mux_sel,
  output logic       running,
  output logic       zero,
  output logic       done
);

`ifdef TIMER_PAUSE_EN
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sync_q, sync_d;
  logic [15:0] cnt_dec;
  logic [15:0] cnt_entry;
  logic        tick;
  logic        digit_ok;

  assign sync_d    = {sync_q[1:0], pgt_1Hz};
  assign tick      = sync_q[1] & ~sync_q[2];
  assign digit_ok  = (digit <= 4'd9);
  assign cnt_entry = {cnt_q[11:0], digit};

  // Borrow chain: seconds tens wraps to 5, ones digits wrap to 9; tens-of-minutes never underflows
  // because RUNNING is only entered with a non-zero count.
  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q[3:0] != 4'd0) begin
      cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
    end else if (cnt_q[7:4] != 4'd0) begin
      cnt_dec = {cnt_q[15:8], cnt_q[7:4] - 4'd1, 4'd9};
    end else if (cnt_q[11:8] != 4'd0) begin
      cnt_dec = {cnt_q[15:12], cnt_q[11:8] - 4'd1, 4'd5, 4'd9};
    end else begin
      cnt_dec = {cnt_q[15:12] - 4'd1, 4'd9, 4'd5, 4'd9};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stop) begin
          cnt_d = '0;
        end else if (start) begin
          if (cnt_q != 16'd0) state_d = RUNNING;
        end else if (load && digit_ok) begin
          cnt_d = cnt_entry;
        end
      end
      RUNNING: begin
        if (stop) begin
`ifdef TIMER_PAUSE_EN
          state_d = PAUSED;
`else
          state_d = IDLE;
          cnt_d   = '0;
`endif
        end else if (tick) begin
          cnt_d = cnt_dec;
          if (cnt_dec == 16'd0) state_d = DONE;
        end
      end
`ifdef TIMER_PAUSE_EN
      PAUSED: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start) begin
          state_d = RUNNING;
        end
      end
`endif
      DONE: begin
        if (!START_HOLD) begin
          state_d = IDLE;
        end else if (load) begin
          state_d = IDLE;
          if (digit_ok) cnt_d = cnt_entry;
        end else if (start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
    end
  end

  assign min_tens = cnt_q[15:12];
  assign min_ones = cnt_q[11:8];
  assign sec_tens = cnt_q[7:4];
  assign sec_ones = cnt_q[3:0];
  assign running  = (state_q == RUNNING);
  assign mux_sel  = (state_q == RUNNING);
  assign done     = (state_q == DONE);
  assign zero     = (cnt_q == 16'd0);

endmodule
